dbus_bridge: RTL

DBUS_BRIDGE -- requirements
Module: dbus_bridge

---
 rtl/dbus_pkg.sv | 21 ++
 rtl/dbus_bridge_if.sv | 34 +++
 rtl/dbus_lane_align.sv | 28 ++
 rtl/dbus_bridge.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared types and constants for the CPU data-bus to RAM bridge.
package dbus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [31:0] MMIO_BASE        = 32'hFFFF_0000;
  localparam logic [3:0]  MMIO_OFF_CYCLE   = 4'h0;
  localparam logic [3:0]  MMIO_OFF_SCRATCH = 4'h4;

  localparam int unsigned TO_CNT_W = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dbus_bridge_if.sv
// CPU-side and RAM-side signal bundle of the bridge. The bridge is the slave;
// the master side is the environment (CPU plus RAM).
interface dbus_bridge_if;
  logic [31:0] memaddr;
  logic [31:0] memin;
  logic        memwrite;
  logic        memread;
  logic [3:0]  iobytes;
  logic [31:0] memout;
  logic        stall;
  logic        bus_err;

  logic        ram_req;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_ack;
  logic [31:0] ram_rdata;

  modport master (
    output memaddr, memin, memwrite, memread, iobytes,
    input  memout, stall, bus_err,
    input  ram_req, ram_we, ram_addr, ram_wdata, ram_be,
    output ram_ack, ram_rdata
  );

  modport slave (
    input  memaddr, memin, memwrite, memread, iobytes,
    output memout, stall, bus_err,
    output ram_req, ram_we, ram_addr, ram_wdata, ram_be,
    input  ram_ack, ram_rdata
  );
endinterface

// File: rtl/dbus_lane_align.sv
// Combinational lane steering: byte enables, store shift, load shift/mask and
// the alignment check for a lane-0-relative access.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [4:0]  shamt;
  logic [31:0] mask;

  assign shamt   = {addr_lo_i, 3'b000};
  assign mask    = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign be_o    = be_i << addr_lo_i;
  assign wdata_o = wdata_i << shamt;
  assign rdata_o = (rdata_i >> shamt) & mask;

  assign misaligned_o = ((be_i == BE_HALF) && addr_lo_i[0]) ||
                        ((be_i == BE_WORD) && (addr_lo_i != 2'b00));

endmodule

// File: rtl/dbus_bridge.sv
// CPU data-bus to RAM bridge: IDLE/BUSY/DONE handshake with timeout.
// Define DBUS_MMIO_EN to decode 0xFFFF_0000..0xFFFF_000F locally (cycle counter, scratch).
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  dbus_bridge_if.slave  bus
);

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d;
  logic [TO_CNT_W-1:0]   cnt_q, cnt_d;

  logic        req;
  logic        in_idle;
  logic        is_mmio;
  logic [31:0] mmio_rdata;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be_in, al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        misaligned;

  assign req     = bus.memread | bus.memwrite;
  assign in_idle = (state_q == StIdle);

  // Live CPU inputs are checked in IDLE; latched copies steer the RAM afterwards.
  assign al_addr_lo = in_idle ? bus.memaddr[1:0] : addr_q[1:0];
  assign al_be_in   = in_idle ? bus.iobytes : be_q;

  dbus_lane_align u_lane_align (
    .addr_lo_i    (al_addr_lo),
    .be_i         (al_be_in),
    .wdata_i      (wdata_q),
    .rdata_i      (bus.ram_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (misaligned)
  );

`ifdef DBUS_MMIO_EN
  logic [31:0] cycle_q;
  logic [31:0] scratch_q, scratch_d;

  assign is_mmio = (bus.memaddr[31:4] == MMIO_BASE[31:4]);

  always_comb begin
    mmio_rdata = 32'h0;
    if (bus.memaddr[3:0] == MMIO_OFF_CYCLE) begin
      mmio_rdata = cycle_q;
    end else if (bus.memaddr[3:0] == MMIO_OFF_SCRATCH) begin
      mmio_rdata = scratch_q;
    end
  end

  always_comb begin
    scratch_d = scratch_q;
    if (in_idle && bus.memwrite && is_mmio && !misaligned &&
        (bus.memaddr[3:0] == MMIO_OFF_SCRATCH)) begin
      scratch_d = bus.memin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      scratch_q <= 32'h0;
    end else begin
      cycle_q   <= cycle_q + 32'h1;
      scratch_q <= scratch_d;
    end
  end
`else
  assign is_mmio    = 1'b0;
  assign mmio_rdata = 32'h0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    be_d          = be_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    bus.stall     = 1'b0;
    bus.bus_err   = 1'b0;
    bus.memout    = 32'h0;
    bus.ram_req   = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = 30'h0;
    bus.ram_wdata = 32'h0;
    bus.ram_be    = 4'h0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (misaligned) begin
            bus.bus_err = 1'b1;
          end else if (is_mmio) begin
            bus.memout = bus.memwrite ? 32'h0 : mmio_rdata;
          end else begin
            bus.stall = 1'b1;
            addr_d    = bus.memaddr;
            wdata_d   = bus.memin;
            be_d      = bus.iobytes;
            we_d      = bus.memwrite;
            cnt_d     = '0;
            state_d   = StBusy;
          end
        end
      end
      StBusy: begin
        bus.stall     = 1'b1;
        bus.ram_req   = 1'b1;
        bus.ram_we    = we_q;
        bus.ram_addr  = addr_q[31:2];
        bus.ram_wdata = al_wdata;
        bus.ram_be    = al_be;
        if (bus.ram_ack) begin
          rdata_d = we_q ? 32'h0 : al_rdata;
          state_d = StDone;
        end else if (cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th BUSY cycle without an ack.
          bus.bus_err = 1'b1;
          rdata_d     = ERR_DATA;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        bus.memout = rdata_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      be_q    <= 4'h0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
